// File: rtl/vec_pipe_adder.sv
// vec_pipe_adder
//   Pipelined multi-lane adder/subtractor. NUM_LANES independent lanes of
//   LANE_WIDTH bits each. The carry chain of every lane is cut into
//   SEG_WIDTH-bit segments, and one register stage resolves one segment, so
//   the latency is NUM_STAGES = LANE_WIDTH/SEG_WIDTH cycles at a throughput
//   of one beat per cycle. Each stage has its own valid bit, and bubbles
//   collapse under backpressure.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  block accepts a beat this cycle (combinational from out_ready)
//   in_sub     in   0: a+b, 1: a-b, applied to all lanes of the beat
//   operand_a  in   lane i at [i*LANE_WIDTH +: LANE_WIDTH]
//   operand_b  in   same packing as operand_a
//   out_valid  out  result beat valid
//   out_ready  in   downstream accepts the result
//   sum        out  per-lane result modulo 2^LANE_WIDTH
//   carry_out  out  per-lane carry out of the MSB (for sub, 1 = no borrow)
//   overflow   out  per-lane two's-complement overflow
module vec_pipe_adder #(
  parameter int LANE_WIDTH = 32,
  parameter int NUM_LANES  = 4,
  parameter int SEG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_sub,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] operand_a,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] operand_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*LANE_WIDTH-1:0] sum,
  output logic [NUM_LANES-1:0]            carry_out,
  output logic [NUM_LANES-1:0]            overflow
);

  localparam int NUM_STAGES = LANE_WIDTH / SEG_WIDTH;
  localparam int VEC_W      = NUM_LANES * LANE_WIDTH;
  localparam int LAST       = NUM_STAGES - 1;

  // One segment of one lane: {carry_out, sum_bits}.
  function automatic logic [SEG_WIDTH:0] seg_add(input logic [SEG_WIDTH-1:0] a,
                                                 input logic [SEG_WIDTH-1:0] b,
                                                 input logic                 cin);
    return {1'b0, a} + {1'b0, b} + {{SEG_WIDTH{1'b0}}, cin};
  endfunction

  // Stage control.
  logic [NUM_STAGES-1:0] v_q, v_d;
  logic [NUM_STAGES-1:0] load;
  logic [NUM_STAGES-1:0] src_v;

  // Stage inputs. Stage 0 reads the ports; stage k reads the register of stage k-1.
  logic [VEC_W-1:0]     src_a [NUM_STAGES];
  logic [VEC_W-1:0]     src_b [NUM_STAGES];
  logic [VEC_W-1:0]     src_s [NUM_STAGES];
  logic [NUM_LANES-1:0] src_c [NUM_STAGES];

  // Stage results.
  logic [VEC_W-1:0]     nxt_s [NUM_STAGES];
  logic [NUM_LANES-1:0] nxt_c [NUM_STAGES];
  logic [NUM_LANES-1:0] ovf_d;

  // Stage registers. Operands ride along with the partially resolved sum.
  logic [VEC_W-1:0]     a_q [NUM_STAGES];
  logic [VEC_W-1:0]     b_q [NUM_STAGES];
  logic [VEC_W-1:0]     s_q [NUM_STAGES];
  logic [NUM_LANES-1:0] c_q [NUM_STAGES];

  // Output registers. These are the only data registers that are reset.
  logic [VEC_W-1:0]     sum_q;
  logic [NUM_LANES-1:0] carry_q;
  logic [NUM_LANES-1:0] ovf_q;

  // Stage k loads when it is empty or when everything downstream can move.
  // That reduces to out_ready or any empty stage at or after k, which is
  // built with a running AND so that no bit of load depends on another.
  always_comb begin
    logic full_from_k;
    full_from_k = 1'b1;
    load        = '0;
    for (int k = LAST; k >= 0; k--) begin
      full_from_k = full_from_k & v_q[k];
      load[k]     = out_ready | ~full_from_k;
    end
  end

  assign in_ready = load[0];

  // Subtraction is a + ~b + 1. The mode is folded into b and the carry-in here,
  // so later stages never need it.
  always_comb begin
    src_v[0] = in_valid;
    src_a[0] = operand_a;
    src_b[0] = operand_b ^ {VEC_W{in_sub}};
    src_s[0] = '0;
    src_c[0] = {NUM_LANES{in_sub}};
    for (int k = 1; k < NUM_STAGES; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
    end
  end

  // Stage k resolves segment k of every lane. Carries never cross lanes.
  always_comb begin
    logic [SEG_WIDTH:0] r;
    r = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      nxt_s[k] = src_s[k];
      nxt_c[k] = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        r = seg_add(src_a[k][i*LANE_WIDTH + k*SEG_WIDTH +: SEG_WIDTH],
                    src_b[k][i*LANE_WIDTH + k*SEG_WIDTH +: SEG_WIDTH],
                    src_c[k][i]);
        nxt_s[k][i*LANE_WIDTH + k*SEG_WIDTH +: SEG_WIDTH] = r[SEG_WIDTH-1:0];
        nxt_c[k][i] = r[SEG_WIDTH];
      end
    end
  end

  // The carry into the lane MSB is recovered as sum ^ a ^ b at that bit.
  // Overflow is that carry XOR the carry out of the MSB.
  always_comb begin
    ovf_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      ovf_d[i] = nxt_s[LAST][i*LANE_WIDTH + LANE_WIDTH - 1]
               ^ src_a[LAST][i*LANE_WIDTH + LANE_WIDTH - 1]
               ^ src_b[LAST][i*LANE_WIDTH + LANE_WIDTH - 1]
               ^ nxt_c[LAST][i];
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      v_d[k] = load[k] ? src_v[k] : v_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // ---- stage registers 0..NUM_STAGES-1 (written only when a beat moves in) ----
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (load[k] && src_v[k]) begin
        a_q[k] <= src_a[k];
        b_q[k] <= src_b[k];
        s_q[k] <= nxt_s[k];
        c_q[k] <= nxt_c[k];
      end
    end
  end

  // ---- output stage (last segment resolved, held while stalled) ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      carry_q <= '0;
      ovf_q   <= '0;
    end else if (load[LAST] && src_v[LAST]) begin
      sum_q   <= nxt_s[LAST];
      carry_q <= nxt_c[LAST];
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign sum       = sum_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_vec_pipe_adder.sv
module tb_vec_pipe_adder;

  localparam int LW = 32;
  localparam int NL = 4;
  localparam int VW = NL * LW;
  localparam int NS = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sub;
  logic [VW-1:0] operand_a;
  logic [VW-1:0] operand_b;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] sum;
  logic [NL-1:0] carry_out;
  logic [NL-1:0] overflow;

  vec_pipe_adder #(.LANE_WIDTH(LW), .NUM_LANES(NL), .SEG_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .operand_a(operand_a), .operand_b(operand_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VW-1:0] s;
    logic [NL-1:0] c;
    logic [NL-1:0] o;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   out_cnt = 0;

  task automatic chk(input string nm, input logic [VW+7:0] act, input logic [VW+7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: per-lane integer arithmetic. Carry is "result does not fit"
  // for add and "no borrow" for sub; overflow is "signed result out of range".
  function automatic exp_t model(input logic sub, input logic [VW-1:0] a, input logic [VW-1:0] b);
    exp_t        e;
    logic [31:0] ua, ub;
    logic [63:0] u;
    longint      sa, sb, r;
    e = '0;
    for (int i = 0; i < NL; i++) begin
      ua = a[i*LW +: LW];
      ub = b[i*LW +: LW];
      sa = longint'($signed(ua));
      sb = longint'($signed(ub));
      if (sub) begin
        e.s[i*LW +: LW] = ua - ub;
        e.c[i] = (ua >= ub);
        r = sa - sb;
      end else begin
        u = {32'd0, ua} + {32'd0, ub};
        e.s[i*LW +: LW] = u[31:0];
        e.c[i] = (u >= 64'h1_0000_0000);
        r = sa + sb;
      end
      e.o[i] = (r > SMAX) || (r < SMIN);
    end
    return e;
  endfunction

  // Scoreboard: every accepted beat is queued; the output is compared with
  // the head whenever out_valid is high, and the head is retired on out_ready.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) exp_q.push_back(model(in_sub, operand_a, operand_b));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {sum, carry_out, overflow}, '0 - 1);
        end else begin
          chk("result", {sum, carry_out, overflow}, {exp_q[0].s, exp_q[0].c, exp_q[0].o});
          if (out_ready) begin
            void'(exp_q.pop_front());
            out_cnt++;
          end
        end
      end
    end
  end

  function automatic logic [31:0] rnd_lane();
    case ($urandom_range(0, 7))
      0: return 32'hFFFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'h0000_0000;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [VW-1:0] rnd_vec();
    return {rnd_lane(), rnd_lane(), rnd_lane(), rnd_lane()};
  endfunction

  // Presents a beat until it is accepted, returning at posedge+1.
  task automatic push_beat(input logic sub, input logic [VW-1:0] a, input logic [VW-1:0] b);
    logic acc;
    int   tries;
    in_valid  = 1'b1;
    in_sub    = sub;
    operand_a = a;
    operand_b = b;
    tries     = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 1000);
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  // Single beat into an empty pipe; lat counts edges from acceptance to out_valid.
  task automatic send_one(input logic sub, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          output logic [VW-1:0] s, output logic [NL-1:0] c,
                          output logic [NL-1:0] o, output int lat);
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    in_sub    = sub;
    operand_a = a;
    operand_b = b;
    chk("empty_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    s = sum;
    c = carry_out;
    o = overflow;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [VW-1:0] s, a, b, held;
    logic [NL-1:0] c, o;
    int            lat, acc, cnt0;
    logic          fire;
    bit            done;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sub    = 1'b0;
    operand_a = '0;
    operand_b = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_outputs", {sum, carry_out, overflow}, 0);
    rst_n = 1'b1;

    // 1: add with wrap on lane 0
    send_one(1'b0, {{3{32'h1234_5678}}, 32'hFFFF_FFFF}, {{3{32'h1111_1111}}, 32'h0000_0001},
             s, c, o, lat);
    chk("t1_latency", lat, 4);
    chk("t1_sum", s, {{3{32'h2345_6789}}, 32'h0000_0000});
    chk("t1_carry", c, 4'b0001);
    chk("t1_ovf", o, 4'b0000);

    // 2: subtraction borrow/overflow corners
    send_one(1'b1, {32'h0, 32'h7, 32'h8000_0000, 32'h5}, {32'h0, 32'h5, 32'h1, 32'h7},
             s, c, o, lat);
    chk("t2_sum", s, {32'h0, 32'h2, 32'h7FFF_FFFF, 32'hFFFF_FFFE});
    chk("t2_carry", c, 4'b1110);
    chk("t2_ovf", o, 4'b0010);
    wait_drain();

    // 3: 8 back-to-back beats alternating add/sub
    fork
      begin
        for (int i = 0; i < 8; i++) push_beat(i[0], rnd_vec(), rnd_vec());
        in_valid = 1'b0;
      end
      begin
        int run, best;
        run = 0;
        best = 0;
        repeat (20) begin
          @(negedge clk);
          if (out_valid && out_ready) run++;
          else run = 0;
          if (run > best) best = run;
        end
        chk("t3_consecutive", best, 8);
      end
    join
    wait_drain();

    // 4: stall with in_valid held high
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sub    = $urandom_range(0, 1);
    operand_a = rnd_vec();
    operand_b = rnd_vec();
    acc  = 0;
    held = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      fire = in_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        acc++;
        in_sub    = $urandom_range(0, 1);
        operand_a = rnd_vec();
        operand_b = rnd_vec();
      end
      if (i == 4) held = sum;
    end
    chk("t4_accepted", acc, 4);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_out_valid", out_valid, 1);
    chk("t4_sum_stable", sum, held);
    cnt0      = out_cnt;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    chk("t4_drained", out_cnt - cnt0, 4);

    // 5: toggling out_ready, random input gaps
    cnt0 = out_cnt;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          push_beat($urandom_range(0, 1), rnd_vec(), rnd_vec());
        end
        in_valid = 1'b0;
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
    chk("t5_count", out_cnt - cnt0, 200);

    // 6: async reset with beats in flight
    for (int i = 0; i < 3; i++) push_beat(1'b0, rnd_vec(), rnd_vec());
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_pre_out_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", out_valid, 0);
    chk("t6_rst_in_ready", in_ready, 1);
    chk("t6_rst_outputs", {sum, carry_out, overflow}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("t6_no_stale_out", out_valid, 0);
    send_one(1'b0, {{3{32'h1234_5678}}, 32'hFFFF_FFFF}, {{3{32'h1111_1111}}, 32'h0000_0001},
             s, c, o, lat);
    chk("t6_latency", lat, 4);
    chk("t6_sum", s, {{3{32'h2345_6789}}, 32'h0000_0000});
    chk("t6_carry", c, 4'b0001);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
